// File: rtl/ex_bus_bridge.sv
// Execute-stage to system-bus bridge: registers a single-cycle core request into a
// valid/ready bus transfer, stalls the core while it is outstanding, aborts on timeout.
module ex_bus_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic [DATA_W-1:0] ex_data_i,
  input  logic              ex_req_i,
  input  logic              ex_we_i,
  output logic [DATA_W-1:0] ex_data_o,
  output logic              hold_flag_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_we_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  input  logic [DATA_W-1:0] m_data_i,
  input  logic              err_clr_i,
  output logic              err_o,
  output logic [ADDR_W-1:0] err_addr_o
);

  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_REQ  = 2'd1;
  localparam logic [1:0]  ST_DONE = 2'd2;
  localparam logic [15:0] WAIT_TC = 16'(TIMEOUT - 1);

  // Bus handshake: m_valid_o is high for every REQ cycle; a transfer completes in the
  // cycle where m_valid_o and m_ready_i are both high, read data sampled in that cycle.

  logic [1:0]        state_q, state_d;
  logic [15:0]       wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_we_q, m_we_d;
  logic [DATA_W-1:0] ex_data_q, ex_data_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              timeout;

  // Ready on the terminal count completes normally, so it masks the timeout.
  assign timeout = (state_q == ST_REQ) && !m_ready_i && (wait_cnt_q == WAIT_TC);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    m_addr_d   = m_addr_q;
    m_data_d   = m_data_q;
    m_we_d     = m_we_q;
    ex_data_d  = ex_data_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;

    if (err_clr_i) err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ex_req_i) begin
          m_addr_d   = ex_addr_i;
          m_data_d   = ex_data_i;
          m_we_d     = ex_we_i;
          wait_cnt_d = '0;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (m_ready_i) begin
          if (!m_we_q) ex_data_d = m_data_i;
          state_d = ST_DONE;
        end else if (timeout) begin
          err_d      = 1'b1;
          err_addr_d = m_addr_q;
          if (!m_we_q) ex_data_d = '0;
          state_d    = ST_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      // The request still visible here belongs to the access just completed.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      m_addr_q   <= '0;
      m_data_q   <= '0;
      m_we_q     <= 1'b0;
      ex_data_q  <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      m_addr_q   <= m_addr_d;
      m_data_q   <= m_data_d;
      m_we_q     <= m_we_d;
      ex_data_q  <= ex_data_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign hold_flag_o = ((state_q == ST_IDLE) && ex_req_i) || (state_q == ST_REQ);
  assign m_valid_o   = (state_q == ST_REQ);
  assign m_addr_o    = m_addr_q;
  assign m_data_o    = m_data_q;
  assign m_we_o      = m_we_q;
  assign ex_data_o   = ex_data_q;
  assign err_o       = err_q;
  assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_ex_bus_bridge.sv
// Directed bench for ex_bus_bridge; a second instance with TIMEOUT=4 shares the stimulus.
module tb_ex_bus_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] ex_addr_i;
  logic [31:0] ex_data_i;
  logic        ex_req_i;
  logic        ex_we_i;
  logic        m_ready_i;
  logic [31:0] m_data_i;
  logic        err_clr_i;

  logic [31:0] ex_data_o, m_addr_o, m_data_o, err_addr_o;
  logic        hold_flag_o, m_we_o, m_valid_o, err_o;
  logic [31:0] ex_data_o4, m_addr_o4, m_data_o4, err_addr_o4;
  logic        hold_flag_o4, m_we_o4, m_valid_o4, err_o4;

  int errors = 0;
  int checks = 0;

  ex_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .ex_addr_i(ex_addr_i), .ex_data_i(ex_data_i),
    .ex_req_i(ex_req_i), .ex_we_i(ex_we_i), .ex_data_o(ex_data_o),
    .hold_flag_o(hold_flag_o), .m_addr_o(m_addr_o), .m_data_o(m_data_o),
    .m_we_o(m_we_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_data_i(m_data_i), .err_clr_i(err_clr_i), .err_o(err_o), .err_addr_o(err_addr_o)
  );

  ex_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst), .ex_addr_i(ex_addr_i), .ex_data_i(ex_data_i),
    .ex_req_i(ex_req_i), .ex_we_i(ex_we_i), .ex_data_o(ex_data_o4),
    .hold_flag_o(hold_flag_o4), .m_addr_o(m_addr_o4), .m_data_o(m_data_o4),
    .m_we_o(m_we_o4), .m_valid_o(m_valid_o4), .m_ready_i(m_ready_i),
    .m_data_i(m_data_i), .err_clr_i(err_clr_i), .err_o(err_o4), .err_addr_o(err_addr_o4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: one access issued in cycle 0, slave ready after 'waits' REQ cycles.
  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic run_access(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic we, input int waits, input logic [31:0] rdata,
                            output int hold_n, output int valid_n, output logic stable,
                            output logic [31:0] req_addr, output logic [31:0] req_data,
                            output logic req_we, output logic [31:0] done_data,
                            output logic done_seen);
    hold_n = 0; valid_n = 0; stable = 1'b1; done_seen = 1'b0;
    req_addr = '0; req_data = '0; req_we = 1'b0; done_data = '0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      @(negedge clk);
      ex_req_i  = (cyc == 0);
      ex_addr_i = (cyc == 0) ? addr : ~addr;
      ex_data_i = (cyc == 0) ? wdata : ~wdata;
      ex_we_i   = (cyc == 0) ? we : ~we;
      m_ready_i = 1'b0;
      m_data_i  = rdata;
      #1;
      if (hold_flag_o) hold_n++;
      if (m_valid_o) begin
        if (valid_n == 0) begin
          req_addr = m_addr_o; req_data = m_data_o; req_we = m_we_o;
        end else if (m_addr_o !== req_addr || m_data_o !== req_data || m_we_o !== req_we) begin
          stable = 1'b0;
        end
        m_ready_i = (valid_n == waits);
        valid_n++;
      end else if (valid_n > 0) begin
        done_seen = 1'b1;
        done_data = ex_data_o;
        break;
      end
    end
    ex_req_i = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", m_valid_o); end
    checks++; if (dut.state_q !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dut.state_q); end
    checks++; if ({m_addr_o, m_data_o, ex_data_o, err_addr_o} !== 128'd0) begin errors++;
      $display("FAIL reset_regs got=%h %h %h %h exp=0", m_addr_o, m_data_o, ex_data_o, err_addr_o); end
    checks++; if (m_we_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL reset_flags got we=%b err=%b exp=0", m_we_o, err_o); end
    checks++; if (dut.wait_cnt_q !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", dut.wait_cnt_q); end
    checks++; if (hold_flag_o !== 1'b0) begin errors++; $display("FAIL reset_hold_idle got=%b exp=0", hold_flag_o); end
    ex_req_i = 1'b1; #1;
    checks++; if (hold_flag_o !== 1'b1) begin errors++; $display("FAIL reset_hold_comb got=%b exp=1", hold_flag_o); end
    ex_req_i = 1'b0; #1;
  endtask

  task automatic test_zero_wait_load;
    int h, v; logic st, w, dn; logic [31:0] a, d, dd;
    run_access(32'h1000_0004, 32'h0, 1'b0, 0, 32'hDEAD_BEEF, h, v, st, a, d, w, dd, dn);
    checks++; if (!dn) begin errors++; $display("FAIL zw_done got=0 exp=1"); end
    checks++; if (v !== 1) begin errors++; $display("FAIL zw_valid_cycles got=%0d exp=1", v); end
    checks++; if (h !== 2) begin errors++; $display("FAIL zw_hold_cycles got=%0d exp=2", h); end
    checks++; if (a !== 32'h1000_0004 || w !== 1'b0) begin errors++; $display("FAIL zw_bus got=%h we=%b exp=10000004 we=0", a, w); end
    checks++; if (dd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL zw_rdata got=%h exp=deadbeef", dd); end
    checks++; if (hold_flag_o !== 1'b0) begin errors++; $display("FAIL zw_done_hold got=%b exp=0", hold_flag_o); end
  endtask

  task automatic test_store_waits;
    int h, v; logic st, w, dn; logic [31:0] a, d, dd;
    run_access(32'h2000_0000, 32'h0000_00A5, 1'b1, 3, 32'h5555_5555, h, v, st, a, d, w, dd, dn);
    checks++; if (!dn) begin errors++; $display("FAIL st_done got=0 exp=1"); end
    checks++; if (v !== 4) begin errors++; $display("FAIL st_valid_cycles got=%0d exp=4", v); end
    checks++; if (h !== 5) begin errors++; $display("FAIL st_hold_cycles got=%0d exp=5", h); end
    checks++; if (a !== 32'h2000_0000 || d !== 32'hA5 || w !== 1'b1) begin errors++;
      $display("FAIL st_bus got=%h %h we=%b exp=20000000 000000a5 we=1", a, d, w); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL st_stable got=%b exp=1", st); end
    checks++; if (dd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_exdata got=%h exp=deadbeef", dd); end
  endtask

  task automatic test_timeout;
    int h, v; logic st, w, dn; logic [31:0] a, d, dd;
    run_access(32'h3000_0010, 32'h0, 1'b0, 1000, 32'h7777_7777, h, v, st, a, d, w, dd, dn);
    checks++; if (!dn) begin errors++; $display("FAIL to_done got=0 exp=1"); end
    checks++; if (h !== 9) begin errors++; $display("FAIL to_hold_cycles got=%0d exp=9", h); end
    checks++; if (v !== 8) begin errors++; $display("FAIL to_valid_cycles got=%0d exp=8", v); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL to_err got=%b exp=1", err_o); end
    checks++; if (err_addr_o !== 32'h3000_0010) begin errors++; $display("FAIL to_err_addr got=%h exp=30000010", err_addr_o); end
    checks++; if (dd !== 32'h0) begin errors++; $display("FAIL to_exdata got=%h exp=0", dd); end
    @(negedge clk); err_clr_i = 1'b1;
    @(negedge clk); err_clr_i = 1'b0; #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL to_clr got=%b exp=0", err_o); end
    checks++; if (err_addr_o !== 32'h3000_0010) begin errors++; $display("FAIL to_addr_kept got=%h exp=30000010", err_addr_o); end
  endtask

  task automatic test_back_to_back;
    logic [9:0] vmask, hmask; logic [31:0] d1, d2, a2;
    vmask = '0; hmask = '0; d1 = '0; d2 = '0; a2 = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ex_req_i  = (c <= 5);
      ex_we_i   = 1'b0;
      ex_addr_i = (c < 3) ? 32'h0000_0100 : 32'h0000_0200;
      m_data_i  = (c < 3) ? 32'h1111_1111 : 32'h2222_2222;
      m_ready_i = 1'b0;
      #1;
      vmask[c] = m_valid_o;
      hmask[c] = hold_flag_o;
      if (m_valid_o) m_ready_i = 1'b1;
      if (c == 2) d1 = ex_data_o;
      if (c == 4) a2 = m_addr_o;
      if (c == 5) d2 = ex_data_o;
    end
    ex_req_i = 1'b0; m_ready_i = 1'b0;
    checks++; if (vmask !== 10'b00_0001_0010) begin errors++; $display("FAIL b2b_valid got=%b exp=0000010010", vmask); end
    checks++; if (hmask !== 10'b00_0001_1011) begin errors++; $display("FAIL b2b_hold got=%b exp=0000011011", hmask); end
    checks++; if (d1 !== 32'h1111_1111 || d2 !== 32'h2222_2222) begin errors++;
      $display("FAIL b2b_rdata got=%h %h exp=11111111 22222222", d1, d2); end
    checks++; if (a2 !== 32'h0000_0200) begin errors++; $display("FAIL b2b_addr2 got=%h exp=00000200", a2); end
  endtask

  task automatic test_reset_mid_access;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      ex_req_i  = (c == 0);
      ex_we_i   = 1'b0;
      ex_addr_i = 32'h6000_0000;
      m_ready_i = 1'b0;
      rst       = (c == 2);
    end
    #1;
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL rma_valid got=%b exp=0", m_valid_o); end
    checks++; if (dut.state_q !== 2'd0) begin errors++; $display("FAIL rma_state got=%0d exp=0", dut.state_q); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rma_err got=%b exp=0", err_o); end
    checks++; if (ex_data_o !== 32'h0) begin errors++; $display("FAIL rma_exdata got=%h exp=0", ex_data_o); end
  endtask

  task automatic test_ready_on_tc;
    int h, v; logic st, w, dn; logic [31:0] a, d, dd;
    run_access(32'h4000_0000, 32'h0, 1'b0, 3, 32'h0000_1234, h, v, st, a, d, w, dd, dn);
    checks++; if (!dn) begin errors++; $display("FAIL tc_done got=0 exp=1"); end
    checks++; if (err_o4 !== 1'b0) begin errors++; $display("FAIL tc_err got=%b exp=0", err_o4); end
    checks++; if (ex_data_o4 !== 32'h0000_1234) begin errors++; $display("FAIL tc_exdata got=%h exp=00001234", ex_data_o4); end
    checks++; if (hold_flag_o4 !== 1'b0 || m_valid_o4 !== 1'b0) begin errors++;
      $display("FAIL tc_done_state got hold=%b valid=%b exp=0 0", hold_flag_o4, m_valid_o4); end
  endtask

  task automatic test_err_set_wins;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      ex_req_i  = (c == 0);
      ex_we_i   = 1'b0;
      ex_addr_i = 32'h5000_0008;
      m_ready_i = 1'b0;
      err_clr_i = 1'b1;
    end
    #1;
    checks++; if (err_o4 !== 1'b1) begin errors++; $display("FAIL esw_err got=%b exp=1", err_o4); end
    checks++; if (err_addr_o4 !== 32'h5000_0008) begin errors++; $display("FAIL esw_addr got=%h exp=50000008", err_addr_o4); end
    checks++; if (ex_data_o4 !== 32'h0) begin errors++; $display("FAIL esw_exdata got=%h exp=0", ex_data_o4); end
    @(negedge clk); err_clr_i = 1'b0;
    for (int c = 0; c < 20 && m_valid_o; c++) @(negedge clk);
    #1;
    checks++; if (m_valid_o !== 1'b0 || err_o !== 1'b1 || err_addr_o !== 32'h5000_0008) begin errors++;
      $display("FAIL esw_main got valid=%b err=%b addr=%h exp=0 1 50000008", m_valid_o, err_o, err_addr_o); end
  endtask

  initial begin
    rst = 1'b1; ex_addr_i = '0; ex_data_i = '0; ex_req_i = 1'b0; ex_we_i = 1'b0;
    m_ready_i = 1'b0; m_data_i = '0; err_clr_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; #1;
    test_reset;
    test_zero_wait_load;
    test_store_waits;
    test_timeout;
    test_back_to_back;
    test_reset_mid_access;
    test_ready_on_tc;
    test_err_set_wins;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_bus_bridge.md
# ex_bus_bridge

Registered bridge between the core's execute-stage memory port and the system bus. It turns the core's combinational single-cycle load/store request into a valid/ready transaction towards slow slaves. While the access is outstanding it stalls the core through the bus hold flag. A timeout abort stops a hung slave from locking the pipeline.

## Interface

Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `TIMEOUT`, default 255: maximum cycles spent in REQ without `m_ready_i` before the access is aborted. Legal range 1..65535.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ex_addr_i`  in  ADDR_W  access address from the execute stage.
- `ex_data_i`  in  DATA_W  store data from the execute stage.
- `ex_req_i`  in  1  access request from the execute stage (combinational on the core side).
- `ex_we_i`  in  1  1 = store, 0 = load.
- `ex_data_o`  out  DATA_W  load data returned to the core.
- `hold_flag_o`  out  1  pipeline stall request; drives the core's bus hold input.
- `m_addr_o`  out  ADDR_W  registered bus address.
- `m_data_o`  out  DATA_W  registered bus write data.
- `m_we_o`  out  1  registered bus write enable.
- `m_valid_o`  out  1  bus request valid.
- `m_ready_i`  in  1  slave accepts the transfer; read data is valid in the same cycle.
- `m_data_i`  in  DATA_W  slave read data.
- `err_clr_i`  in  1  clears the sticky error.
- `err_o`  out  1  sticky timeout error.
- `err_addr_o`  out  ADDR_W  address of the most recent timed-out access.

## Operation

- FSM states: IDLE, REQ, DONE.
- IDLE with `ex_req_i=1`:
  - capture `ex_addr_i`, `ex_data_i`, `ex_we_i` into `m_addr_o`/`m_data_o`/`m_we_o`;
  - clear the wait counter;
  - go to REQ.
- REQ:
  - `m_valid_o=1`.
  - On `m_ready_i=1`: if the access is a read, register `m_data_i` into `ex_data_o`. Then go to DONE.
  - Otherwise increment the wait counter. When the counter equals TIMEOUT-1 and `m_ready_i=0`:
    - set `err_o`;
    - load `err_addr_o` with `m_addr_o`;
    - for a read, `ex_data_o` becomes 0;
    - go to DONE.
- DONE:
  - hold released for exactly one cycle, so the core commits the instruction.
  - `ex_req_i` is ignored in this cycle because it still belongs to the completed access.
  - Always go to IDLE.
- `hold_flag_o` = (IDLE and `ex_req_i`) or REQ. It is combinational, so the core stalls in the same cycle the request appears.
- `ex_data_o` changes only on read completion or read timeout. Stores leave it unchanged.
- Simultaneous `m_ready_i=1` and timeout terminal count: ready wins; no error is raised.
- `err_clr_i` and a new timeout in the same cycle: the set wins, and `err_addr_o` updates.
- `m_addr_o`, `m_data_o` and `m_we_o` stay stable for the whole of REQ. They hold their last values outside REQ.

## Timing

- Reset values: state=IDLE; `m_valid_o=0`; `m_addr_o=0`; `m_data_o=0`; `m_we_o=0`; `ex_data_o=0`; `err_o=0`; `err_addr_o=0`; wait counter 0. `hold_flag_o` follows `ex_req_i` combinationally from the first cycle after reset.
- Zero-wait-state access: cycle 0 IDLE (hold=1), cycle 1 REQ (valid=1, ready=1), cycle 2 DONE (hold=0, `ex_data_o` valid). That is 2 hold cycles and 3 cycles per access.
- Each slave wait state adds 1 hold cycle.
- Timeout access: hold lasts 1+TIMEOUT cycles, then DONE.
- Back-to-back accesses: DONE→IDLE→REQ; the minimum spacing between `m_valid_o` assertions is 2 idle cycles.
- `rst` during REQ: the access is abandoned. Next cycle: IDLE, `m_valid_o=0`, no error recorded.

## Test plan

- **Zero-wait load.** Stimulus: load at 0x1000_0004; slave ready in the first REQ cycle with data 0xDEAD_BEEF. Required: `m_valid_o` high for 1 cycle, hold high for 2 cycles, `ex_data_o`=0xDEAD_BEEF in the DONE cycle.
- **Store with 3 wait states.** Stimulus: store of 0x0000_00A5 to 0x2000_0000. Required: `m_we_o=1`, `m_data_o`=0xA5 stable for 4 REQ cycles, hold high for 5 cycles, `ex_data_o` unchanged.
- **Timeout.** Stimulus: TIMEOUT=8, slave never ready, read at 0x3000_0010. Required: hold high for 9 cycles, `err_o=1`, `err_addr_o`=0x3000_0010, `ex_data_o=0`. Then `err_clr_i` pulse → `err_o=0`.
- **Back-to-back.** Stimulus: two consecutive loads, `ex_req_i` held high through DONE. Required: exactly two bus transactions, not three; DONE cycle shows hold=0.
- **Reset mid-access.** Stimulus: `rst` pulse in the second REQ cycle. Required: next cycle `m_valid_o=0`, state IDLE, `err_o=0`, `ex_data_o=0`.
- **Ready on terminal count.** Stimulus: TIMEOUT=4, ready asserted in the 4th REQ cycle with data 0x1234. Required: no error, `ex_data_o`=0x1234.
